// File: rtl/uart_pkg.sv
// Shared types and constants for the UART FIFO core: line-format enums, FSM states,
// error-tag bit positions and oversampling constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID        = 8;

  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAMING = 1;
  localparam int ERR_BREAK   = 2;

  typedef enum logic [1:0] {DBITS_5, DBITS_6, DBITS_7, DBITS_8} data_bits_e;

  typedef enum logic [2:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_PARITY, TXS_STOP} tx_state_e;

  typedef enum logic [2:0] {
    RXS_IDLE, RXS_START, RXS_DATA, RXS_PARITY, RXS_STOP, RXS_BREAK
  } rx_state_e;

  // Index of the last data bit for a character length (5 bits -> 4 ... 8 bits -> 7).
  function automatic logic [2:0] last_bit_idx(data_bits_e db);
    return 3'd4 + {1'b0, db};
  endfunction

  function automatic logic [7:0] data_mask(data_bits_e db);
    return 8'hFF >> (2'd3 - db);
  endfunction

endpackage

// File: rtl/uart_fifo_core_if.sv
// Host-side register interface of the UART FIFO core: line config, TX FIFO push side,
// RX FIFO FWFT pop side, IRQ and overflow status.
interface uart_fifo_core_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [BAUD_W-1:0] BAUD_VAL;
  data_bits_e        DATA_BITS;
  logic              PARITY_EN;
  logic              ODD_N_EVEN;
  logic              STOP2;
  logic [7:0]        TX_DATA;
  logic              TX_WR;
  logic              TX_FULL;
  logic              TX_EMPTY;
  logic [7:0]        RX_DATA;
  logic [2:0]        RX_ERR;
  logic              RX_RD;
  logic              RX_VALID;
  logic [AW:0]       RX_LEVEL;
  logic [AW:0]       RX_THRESH;
  logic              RX_IRQ;
  logic              OVERFLOW;
  logic              OVF_CLR;

  modport master (
    output BAUD_VAL, DATA_BITS, PARITY_EN, ODD_N_EVEN, STOP2, TX_DATA, TX_WR,
           RX_RD, RX_THRESH, OVF_CLR,
    input  TX_FULL, TX_EMPTY, RX_DATA, RX_ERR, RX_VALID, RX_LEVEL, RX_IRQ, OVERFLOW
  );

  modport slave (
    input  BAUD_VAL, DATA_BITS, PARITY_EN, ODD_N_EVEN, STOP2, TX_DATA, TX_WR,
           RX_RD, RX_THRESH, OVF_CLR,
    output TX_FULL, TX_EMPTY, RX_DATA, RX_ERR, RX_VALID, RX_LEVEL, RX_IRQ, OVERFLOW
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty are derived by the user from level.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != DEPTH[AW:0]) || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage has no reset; contents are only observable once level says they are valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// UART core: shared 16x baud tick, TX shifter fed by a TX FIFO, RX sampler feeding a
// tagged RX FIFO, plus fill-level IRQ and sticky overflow.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int BAUD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  uart_fifo_core_if.slave    host,
  input  logic               RX,
  output logic               TX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL   = FIFO_DEPTH[AW:0];
  localparam logic [4:0]  BIT_LAST   = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]  STOP2_LAST = 5'(2 * OVERSAMPLE - 1);

  logic [BAUD_W-1:0] baud_cnt;
  logic              tick;

  assign tick = (baud_cnt == '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  baud_cnt <= '0;
    else if (tick) baud_cnt <= host.BAUD_VAL;
    else           baud_cnt <= baud_cnt - 1'b1;
  end

  // ---------------- transmit ----------------
  tx_state_e   tx_state;
  logic [4:0]  tx_tick;
  logic [2:0]  tx_bit, tx_last;
  logic [7:0]  tx_shreg, tx_head;
  logic        tx_par, tx_par_en, tx_stop2;
  logic [AW:0] tx_level;
  logic        tx_fifo_empty, tx_bit_end, tx_stop_done, tx_load;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .CLK, .RESET_N, .push(host.TX_WR), .wdata(host.TX_DATA), .pop(tx_load),
    .rdata(tx_head), .level(tx_level)
  );

  assign tx_fifo_empty = (tx_level == '0);
  assign host.TX_FULL  = (tx_level == FULL_LVL);
  assign host.TX_EMPTY = tx_fifo_empty && (tx_state == TXS_IDLE);

  assign tx_bit_end   = tick && (tx_tick == BIT_LAST);
  assign tx_stop_done = tick && (tx_state == TXS_STOP) &&
                        (tx_tick == (tx_stop2 ? STOP2_LAST : BIT_LAST));
  // Reloading straight out of STOP keeps back-to-back characters gap-free.
  assign tx_load = !tx_fifo_empty && ((tx_state == TXS_IDLE) || tx_stop_done);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_state  <= TXS_IDLE;
      tx_tick   <= '0;
      tx_bit    <= '0;
      tx_last   <= '0;
      tx_shreg  <= '0;
      tx_par    <= 1'b0;
      tx_par_en <= 1'b0;
      tx_stop2  <= 1'b0;
      TX        <= 1'b1;
    end else if (tx_load) begin
      tx_state  <= TXS_START;
      tx_tick   <= '0;
      tx_shreg  <= tx_head;
      tx_last   <= last_bit_idx(host.DATA_BITS);
      tx_par    <= ^(tx_head & data_mask(host.DATA_BITS)) ^ host.ODD_N_EVEN;
      tx_par_en <= host.PARITY_EN;
      tx_stop2  <= host.STOP2;
      TX        <= 1'b0;
    end else if (tick && tx_state != TXS_IDLE) begin
      tx_tick <= ((tx_bit_end && tx_state != TXS_STOP) || tx_stop_done) ? '0 : tx_tick + 1'b1;
      case (tx_state)
        TXS_START: if (tx_bit_end) begin
          tx_state <= TXS_DATA;
          tx_bit   <= '0;
          TX       <= tx_shreg[0];
        end
        TXS_DATA: if (tx_bit_end) begin
          if (tx_bit != tx_last) begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shreg <= tx_shreg >> 1;
            TX       <= tx_shreg[1];
          end else if (tx_par_en) begin
            tx_state <= TXS_PARITY;
            TX       <= tx_par;
          end else begin
            tx_state <= TXS_STOP;
            TX       <= 1'b1;
          end
        end
        TXS_PARITY: if (tx_bit_end) begin
          tx_state <= TXS_STOP;
          TX       <= 1'b1;
        end
        TXS_STOP: if (tx_stop_done) tx_state <= TXS_IDLE;
        default: ;
      endcase
    end
  end

  // ---------------- receive ----------------
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_line, rx_prev;

  assign rx_line = rx_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_sync <= '1;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], RX};
      rx_prev <= rx_line;
    end
  end

  rx_state_e   rx_state;
  logic [3:0]  rx_tick;
  logic [2:0]  rx_bit, rx_last;
  logic [7:0]  rx_data;
  logic        rx_par_en, rx_odd, rx_par_acc, rx_par_err, rx_seen_one;
  logic        rx_sample, rx_push;
  logic [2:0]  rx_tag;
  logic [10:0] rx_head;
  logic [AW:0] rx_level;
  logic        rx_irq, overflow;

  // START samples mid-bit at tick 8; every later bit is 16 ticks on, i.e. mid-bit again.
  assign rx_sample = tick && (rx_tick == ((rx_state == RXS_START) ? 4'(MID - 1) : 4'(OVERSAMPLE - 1)));
  assign rx_push   = (rx_state == RXS_STOP) && rx_sample;

  always_comb begin
    rx_tag              = '0;  // NOTE: defaulting every always_comb output first rules out latches.
    rx_tag[ERR_PARITY]  = rx_par_err;
    rx_tag[ERR_FRAMING] = !rx_line;
    rx_tag[ERR_BREAK]   = !rx_line && !rx_seen_one;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_state    <= RXS_IDLE;
      rx_tick     <= '0;
      rx_bit      <= '0;
      rx_last     <= '0;
      rx_data     <= '0;
      rx_par_en   <= 1'b0;
      rx_odd      <= 1'b0;
      rx_par_acc  <= 1'b0;
      rx_par_err  <= 1'b0;
      rx_seen_one <= 1'b0;
    end else begin
      if (tick && rx_state != RXS_IDLE && rx_state != RXS_BREAK)
        rx_tick <= rx_sample ? '0 : rx_tick + 1'b1;
      case (rx_state)
        RXS_IDLE: if (rx_prev && !rx_line) begin
          rx_state    <= RXS_START;
          rx_tick     <= '0;
          rx_bit      <= '0;
          rx_last     <= last_bit_idx(host.DATA_BITS);
          rx_par_en   <= host.PARITY_EN;
          rx_odd      <= host.ODD_N_EVEN;
          rx_data     <= '0;
          rx_par_acc  <= 1'b0;
          rx_par_err  <= 1'b0;
          rx_seen_one <= 1'b0;
        end
        RXS_START: if (rx_sample) rx_state <= rx_line ? RXS_IDLE : RXS_DATA;
        RXS_DATA: if (rx_sample) begin
          rx_data[rx_bit] <= rx_line;
          rx_par_acc      <= rx_par_acc ^ rx_line;
          rx_seen_one     <= rx_seen_one | rx_line;
          if (rx_bit != rx_last) rx_bit   <= rx_bit + 1'b1;
          else                   rx_state <= rx_par_en ? RXS_PARITY : RXS_STOP;
        end
        RXS_PARITY: if (rx_sample) begin
          rx_par_err  <= (rx_line != (rx_par_acc ^ rx_odd));
          rx_seen_one <= rx_seen_one | rx_line;
          rx_state    <= RXS_STOP;
        end
        RXS_STOP: if (rx_sample) rx_state <= rx_tag[ERR_BREAK] ? RXS_BREAK : RXS_IDLE;
        RXS_BREAK: if (rx_line) rx_state <= RXS_IDLE;
        default: rx_state <= RXS_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(.WIDTH(11), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .CLK, .RESET_N, .push(rx_push), .wdata({rx_tag, rx_data}), .pop(host.RX_RD),
    .rdata(rx_head), .level(rx_level)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_irq   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_irq <= (host.RX_THRESH != '0) && (rx_level >= host.RX_THRESH);
      if (rx_push && (rx_level == FULL_LVL) && !host.RX_RD) overflow <= 1'b1;
      else if (host.OVF_CLR)                                 overflow <= 1'b0;
    end
  end

  assign host.RX_VALID = (rx_level != '0);
  assign host.RX_LEVEL = rx_level;
  assign host.RX_DATA  = host.RX_VALID ? rx_head[7:0]  : '0;
  assign host.RX_ERR   = host.RX_VALID ? rx_head[10:8] : '0;
  assign host.RX_IRQ   = rx_irq;
  assign host.OVERFLOW = overflow;

endmodule
